// File: rtl/axi_mem_arb_pkg.sv
// Shared types, constants and helpers for the AXI memory arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axi_mem_arb_pkg;

  typedef logic [1:0] axi_resp_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10,
    AXI_BURST_RSVD  = 2'b11
  } axi_burst_t;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

  // Upper bound on ports the round-robin helper can search.
  localparam int RR_MAX_PORTS = 64;

  // Bits needed to name a port; never below 1 so slices stay legal.
  function automatic int port_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First requesting port at or after ptr, wrapping modulo n.
  // Returns ptr when nothing requests; callers qualify with |req.
  function automatic int unsigned rr_pick(input logic [RR_MAX_PORTS-1:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < RR_MAX_PORTS; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[5:0]]) begin
          found   = 1'b1;
          rr_pick = idx;
        end
      end
    end
  endfunction

endpackage

// File: rtl/axi_mem_arb_fifo.sv
// Small synchronous FIFO of port indices steering W beats in AW grant order.
// Latency: written entry visible at dout_o the cycle after push.
// Backpressure: full_o/empty_o are registered; push when full and pop when empty are ignored.
module axi_mem_arb_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_BITS = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic                do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  // Advance pointers and occupancy; flags derive from the next count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    full_d  = (cnt_d == CNT_BITS'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  // Control state register with synchronous reset to empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage write; contents need no reset since empty_q guards reads.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Round-robin N-port AXI4 arbiter onto one memory port; port index prefixed to IDs; optional per-port limit via AXI_MEM_ARB_LIMIT_EN.
// Latency: all channels are combinational pass-through, 0 cycles.
// Backpressure: only the granted/routed port sees downstream ready; AW stalls while the W steering queue is full.
module axi_mem_arbiter
  import axi_mem_arb_pkg::*;
#(
  parameter int N_PORTS         = 2,
  parameter int ADDR_BITS       = 32,
  parameter int DATA_BITS       = 64,
  parameter int ID_BITS         = 5,
  parameter int WQ_DEPTH        = 4,
  parameter int MAX_OUTSTANDING = 8,
  localparam int PORT_BITS      = port_bits(N_PORTS),
  localparam int STRB_BITS      = DATA_BITS / 8,
  localparam int OID_BITS       = ID_BITS + PORT_BITS
) (
  input  logic                           clock,
  input  logic                           reset,
  // upstream AR
  input  logic [N_PORTS-1:0]             in_ar_valid,
  output logic [N_PORTS-1:0]             in_ar_ready,
  input  logic [N_PORTS*ADDR_BITS-1:0]   in_ar_bits_addr,
  input  logic [N_PORTS*8-1:0]           in_ar_bits_len,
  input  logic [N_PORTS*3-1:0]           in_ar_bits_size,
  input  logic [N_PORTS*2-1:0]           in_ar_bits_burst,
  input  logic [N_PORTS*ID_BITS-1:0]     in_ar_bits_id,
  // upstream AW
  input  logic [N_PORTS-1:0]             in_aw_valid,
  output logic [N_PORTS-1:0]             in_aw_ready,
  input  logic [N_PORTS*ADDR_BITS-1:0]   in_aw_bits_addr,
  input  logic [N_PORTS*8-1:0]           in_aw_bits_len,
  input  logic [N_PORTS*3-1:0]           in_aw_bits_size,
  input  logic [N_PORTS*2-1:0]           in_aw_bits_burst,
  input  logic [N_PORTS*ID_BITS-1:0]     in_aw_bits_id,
  // upstream W
  input  logic [N_PORTS-1:0]             in_w_valid,
  output logic [N_PORTS-1:0]             in_w_ready,
  input  logic [N_PORTS*DATA_BITS-1:0]   in_w_bits_data,
  input  logic [N_PORTS*STRB_BITS-1:0]   in_w_bits_strb,
  input  logic [N_PORTS-1:0]             in_w_bits_last,
  // upstream R
  output logic [N_PORTS-1:0]             in_r_valid,
  input  logic [N_PORTS-1:0]             in_r_ready,
  output logic [N_PORTS*ID_BITS-1:0]     in_r_bits_id,
  output logic [N_PORTS*DATA_BITS-1:0]   in_r_bits_data,
  output logic [N_PORTS*2-1:0]           in_r_bits_resp,
  output logic [N_PORTS-1:0]             in_r_bits_last,
  // upstream B
  output logic [N_PORTS-1:0]             in_b_valid,
  input  logic [N_PORTS-1:0]             in_b_ready,
  output logic [N_PORTS*ID_BITS-1:0]     in_b_bits_id,
  output logic [N_PORTS*2-1:0]           in_b_bits_resp,
  // downstream AR
  output logic                           out_ar_valid,
  input  logic                           out_ar_ready,
  output logic [ADDR_BITS-1:0]           out_ar_bits_addr,
  output logic [7:0]                     out_ar_bits_len,
  output logic [2:0]                     out_ar_bits_size,
  output logic [1:0]                     out_ar_bits_burst,
  output logic [OID_BITS-1:0]            out_ar_bits_id,
  // downstream AW
  output logic                           out_aw_valid,
  input  logic                           out_aw_ready,
  output logic [ADDR_BITS-1:0]           out_aw_bits_addr,
  output logic [7:0]                     out_aw_bits_len,
  output logic [2:0]                     out_aw_bits_size,
  output logic [1:0]                     out_aw_bits_burst,
  output logic [OID_BITS-1:0]            out_aw_bits_id,
  // downstream W
  output logic                           out_w_valid,
  input  logic                           out_w_ready,
  output logic [DATA_BITS-1:0]           out_w_bits_data,
  output logic [STRB_BITS-1:0]           out_w_bits_strb,
  output logic                           out_w_bits_last,
  // downstream R
  input  logic                           out_r_valid,
  output logic                           out_r_ready,
  input  logic [OID_BITS-1:0]            out_r_bits_id,
  input  logic [DATA_BITS-1:0]           out_r_bits_data,
  input  logic [1:0]                     out_r_bits_resp,
  input  logic                           out_r_bits_last,
  // downstream B
  input  logic                           out_b_valid,
  output logic                           out_b_ready,
  input  logic [OID_BITS-1:0]            out_b_bits_id,
  input  logic [1:0]                     out_b_bits_resp
);

  localparam logic [N_PORTS-1:0] ONE_HOT0 = N_PORTS'(1);

  function automatic logic [PORT_BITS-1:0] next_port(input logic [PORT_BITS-1:0] p);
    return (int'(p) == N_PORTS - 1) ? '0 : p + 1'b1;
  endfunction

  logic [N_PORTS-1:0]   ar_cand, aw_cand;
  logic [PORT_BITS-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic                 ar_lock_q, ar_lock_d, aw_lock_q, aw_lock_d;
  logic [PORT_BITS-1:0] ar_lock_port_q, ar_lock_port_d, aw_lock_port_q, aw_lock_port_d;
  logic [PORT_BITS-1:0] ar_pick, aw_pick, ar_sel, aw_sel;
  int                   ar_idx, aw_idx;
  logic                 ar_hs, aw_hs;
  logic [PORT_BITS-1:0] wq_head;
  logic                 wq_full, wq_empty, wq_vld, wq_pop;
  int                   w_idx;
  logic [PORT_BITS-1:0] r_port, b_port;
  logic                 r_ok, b_ok;

  // ---------------- read address arbitration ----------------
  assign ar_pick = PORT_BITS'(rr_pick(RR_MAX_PORTS'(ar_cand), 32'(rd_ptr_q), N_PORTS));
  assign ar_sel  = ar_lock_q ? ar_lock_port_q : ar_pick;
  assign ar_idx  = int'(ar_sel);

  assign out_ar_valid      = !reset && (ar_lock_q || (|ar_cand));
  assign out_ar_bits_addr  = in_ar_bits_addr[ar_idx*ADDR_BITS +: ADDR_BITS];
  assign out_ar_bits_len   = in_ar_bits_len[ar_idx*8 +: 8];
  assign out_ar_bits_size  = in_ar_bits_size[ar_idx*3 +: 3];
  assign out_ar_bits_burst = in_ar_bits_burst[ar_idx*2 +: 2];
  assign out_ar_bits_id    = {ar_sel, in_ar_bits_id[ar_idx*ID_BITS +: ID_BITS]};
  assign in_ar_ready       = (out_ar_valid && out_ar_ready) ? (ONE_HOT0 << ar_sel) : '0;
  assign ar_hs             = out_ar_valid && out_ar_ready;

  // Hold a stalled grant until accepted; rotate priority past each accepted port.
  always_comb begin
    ar_lock_d      = ar_lock_q;
    ar_lock_port_d = ar_lock_port_q;
    rd_ptr_d       = rd_ptr_q;
    if (ar_hs) begin
      ar_lock_d = 1'b0;
      rd_ptr_d  = next_port(ar_sel);
    end else if (out_ar_valid) begin
      ar_lock_d      = 1'b1;
      ar_lock_port_d = ar_sel;
    end
  end

  // ---------------- write address arbitration ----------------
  assign aw_pick = PORT_BITS'(rr_pick(RR_MAX_PORTS'(aw_cand), 32'(wr_ptr_q), N_PORTS));
  assign aw_sel  = aw_lock_q ? aw_lock_port_q : aw_pick;
  assign aw_idx  = int'(aw_sel);

  // Full can only rise on a push, i.e. never while a grant is locked,
  // so gating valid on it cannot retract an offered AW.
  assign out_aw_valid      = !reset && !wq_full && (aw_lock_q || (|aw_cand));
  assign out_aw_bits_addr  = in_aw_bits_addr[aw_idx*ADDR_BITS +: ADDR_BITS];
  assign out_aw_bits_len   = in_aw_bits_len[aw_idx*8 +: 8];
  assign out_aw_bits_size  = in_aw_bits_size[aw_idx*3 +: 3];
  assign out_aw_bits_burst = in_aw_bits_burst[aw_idx*2 +: 2];
  assign out_aw_bits_id    = {aw_sel, in_aw_bits_id[aw_idx*ID_BITS +: ID_BITS]};
  assign in_aw_ready       = (out_aw_valid && out_aw_ready) ? (ONE_HOT0 << aw_sel) : '0;
  assign aw_hs             = out_aw_valid && out_aw_ready;

  // Same lock/rotate policy as the read side.
  always_comb begin
    aw_lock_d      = aw_lock_q;
    aw_lock_port_d = aw_lock_port_q;
    wr_ptr_d       = wr_ptr_q;
    if (aw_hs) begin
      aw_lock_d = 1'b0;
      wr_ptr_d  = next_port(aw_sel);
    end else if (out_aw_valid) begin
      aw_lock_d      = 1'b1;
      aw_lock_port_d = aw_sel;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      ar_lock_q      <= 1'b0;
      aw_lock_q      <= 1'b0;
      ar_lock_port_q <= '0;
      aw_lock_port_q <= '0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      ar_lock_q      <= ar_lock_d;
      aw_lock_q      <= aw_lock_d;
      ar_lock_port_q <= ar_lock_port_d;
      aw_lock_port_q <= aw_lock_port_d;
    end
  end

  // ---------------- W steering ----------------
  axi_mem_arb_fifo #(
    .WIDTH (PORT_BITS),
    .DEPTH (WQ_DEPTH)
  ) u_wq (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (aw_hs),
    .din_i   (aw_sel),
    .pop_i   (wq_pop),
    .dout_o  (wq_head),
    .full_o  (wq_full),
    .empty_o (wq_empty)
  );

  assign wq_vld          = !reset && !wq_empty;
  assign w_idx           = int'(wq_head);
  assign out_w_valid     = wq_vld && in_w_valid[wq_head];
  assign out_w_bits_data = in_w_bits_data[w_idx*DATA_BITS +: DATA_BITS];
  assign out_w_bits_strb = in_w_bits_strb[w_idx*STRB_BITS +: STRB_BITS];
  assign out_w_bits_last = in_w_bits_last[wq_head];
  // W from a port not at the head (including W ahead of its AW) waits here.
  assign in_w_ready      = (wq_vld && out_w_ready) ? (ONE_HOT0 << wq_head) : '0;
  assign wq_pop          = out_w_valid && out_w_ready && out_w_bits_last;

  // ---------------- R / B routing by ID prefix ----------------
  assign r_port = out_r_bits_id[OID_BITS-1:ID_BITS];
  assign b_port = out_b_bits_id[OID_BITS-1:ID_BITS];
  assign r_ok   = int'(r_port) < N_PORTS;
  assign b_ok   = int'(b_port) < N_PORTS;

  // Responses for a nonexistent port are sunk so the memory never wedges.
  assign in_r_valid     = (!reset && r_ok && out_r_valid) ? (ONE_HOT0 << r_port) : '0;
  assign out_r_ready    = !reset && (r_ok ? in_r_ready[r_port] : 1'b1);
  assign in_r_bits_id   = {N_PORTS{out_r_bits_id[ID_BITS-1:0]}};
  assign in_r_bits_data = {N_PORTS{out_r_bits_data}};
  assign in_r_bits_resp = {N_PORTS{out_r_bits_resp}};
  assign in_r_bits_last = {N_PORTS{out_r_bits_last}};

  assign in_b_valid     = (!reset && b_ok && out_b_valid) ? (ONE_HOT0 << b_port) : '0;
  assign out_b_ready    = !reset && (b_ok ? in_b_ready[b_port] : 1'b1);
  assign in_b_bits_id   = {N_PORTS{out_b_bits_id[ID_BITS-1:0]}};
  assign in_b_bits_resp = {N_PORTS{out_b_bits_resp}};

  // ---------------- outstanding limit ----------------
`ifdef AXI_MEM_ARB_LIMIT_EN
  localparam int CNT_BITS = $clog2(MAX_OUTSTANDING + 1);

  logic [N_PORTS-1:0][CNT_BITS-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [N_PORTS-1:0]               rd_at_max, wr_at_max;
  logic                             r_done, b_done;

  assign r_done = out_r_valid && out_r_ready && r_ok && out_r_bits_last;
  assign b_done = out_b_valid && out_b_ready && b_ok;

  // Count requests in flight per port; inc and dec together cancel.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    for (int p = 0; p < N_PORTS; p++) begin
      if ((ar_hs && ar_idx == p) && !(r_done && int'(r_port) == p))
        rd_cnt_d[p] = rd_cnt_q[p] + 1'b1;
      else if (!(ar_hs && ar_idx == p) && (r_done && int'(r_port) == p) && rd_cnt_q[p] != '0)
        rd_cnt_d[p] = rd_cnt_q[p] - 1'b1;
      if ((aw_hs && aw_idx == p) && !(b_done && int'(b_port) == p))
        wr_cnt_d[p] = wr_cnt_q[p] + 1'b1;
      else if (!(aw_hs && aw_idx == p) && (b_done && int'(b_port) == p) && wr_cnt_q[p] != '0)
        wr_cnt_d[p] = wr_cnt_q[p] - 1'b1;
      rd_at_max[p] = (rd_cnt_q[p] == CNT_BITS'(MAX_OUTSTANDING));
      wr_at_max[p] = (wr_cnt_q[p] == CNT_BITS'(MAX_OUTSTANDING));
    end
  end

  // Outstanding counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign ar_cand = in_ar_valid & ~rd_at_max;
  assign aw_cand = in_aw_valid & ~wr_at_max;
`else
  assign ar_cand = in_ar_valid;
  assign aw_cand = in_aw_valid;
`endif

endmodule

// File: tb/tb_axi_mem_arbiter.sv
module tb_axi_mem_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   in_ar_valid, in_ar_ready;
  logic [63:0]  in_ar_bits_addr;
  logic [15:0]  in_ar_bits_len;
  logic [5:0]   in_ar_bits_size;
  logic [3:0]   in_ar_bits_burst;
  logic [9:0]   in_ar_bits_id;
  logic [1:0]   in_aw_valid, in_aw_ready;
  logic [63:0]  in_aw_bits_addr;
  logic [15:0]  in_aw_bits_len;
  logic [5:0]   in_aw_bits_size;
  logic [3:0]   in_aw_bits_burst;
  logic [9:0]   in_aw_bits_id;
  logic [1:0]   in_w_valid, in_w_ready;
  logic [127:0] in_w_bits_data;
  logic [15:0]  in_w_bits_strb;
  logic [1:0]   in_w_bits_last;
  logic [1:0]   in_r_valid, in_r_ready;
  logic [9:0]   in_r_bits_id;
  logic [127:0] in_r_bits_data;
  logic [3:0]   in_r_bits_resp;
  logic [1:0]   in_r_bits_last;
  logic [1:0]   in_b_valid, in_b_ready;
  logic [9:0]   in_b_bits_id;
  logic [3:0]   in_b_bits_resp;
  logic         out_ar_valid, out_ar_ready;
  logic [31:0]  out_ar_bits_addr;
  logic [7:0]   out_ar_bits_len;
  logic [2:0]   out_ar_bits_size;
  logic [1:0]   out_ar_bits_burst;
  logic [5:0]   out_ar_bits_id;
  logic         out_aw_valid, out_aw_ready;
  logic [31:0]  out_aw_bits_addr;
  logic [7:0]   out_aw_bits_len;
  logic [2:0]   out_aw_bits_size;
  logic [1:0]   out_aw_bits_burst;
  logic [5:0]   out_aw_bits_id;
  logic         out_w_valid, out_w_ready;
  logic [63:0]  out_w_bits_data;
  logic [7:0]   out_w_bits_strb;
  logic         out_w_bits_last;
  logic         out_r_valid, out_r_ready;
  logic [5:0]   out_r_bits_id;
  logic [63:0]  out_r_bits_data;
  logic [1:0]   out_r_bits_resp;
  logic         out_r_bits_last;
  logic         out_b_valid, out_b_ready;
  logic [5:0]   out_b_bits_id;
  logic [1:0]   out_b_bits_resp;

  int checks;
  int failures;

  always #5 clock = ~clock;

  axi_mem_arbiter #(
    .N_PORTS(2), .ADDR_BITS(32), .DATA_BITS(64), .ID_BITS(5),
    .WQ_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clock(clock), .reset(reset),
    .in_ar_valid(in_ar_valid), .in_ar_ready(in_ar_ready), .in_ar_bits_addr(in_ar_bits_addr),
    .in_ar_bits_len(in_ar_bits_len), .in_ar_bits_size(in_ar_bits_size),
    .in_ar_bits_burst(in_ar_bits_burst), .in_ar_bits_id(in_ar_bits_id),
    .in_aw_valid(in_aw_valid), .in_aw_ready(in_aw_ready), .in_aw_bits_addr(in_aw_bits_addr),
    .in_aw_bits_len(in_aw_bits_len), .in_aw_bits_size(in_aw_bits_size),
    .in_aw_bits_burst(in_aw_bits_burst), .in_aw_bits_id(in_aw_bits_id),
    .in_w_valid(in_w_valid), .in_w_ready(in_w_ready), .in_w_bits_data(in_w_bits_data),
    .in_w_bits_strb(in_w_bits_strb), .in_w_bits_last(in_w_bits_last),
    .in_r_valid(in_r_valid), .in_r_ready(in_r_ready), .in_r_bits_id(in_r_bits_id),
    .in_r_bits_data(in_r_bits_data), .in_r_bits_resp(in_r_bits_resp), .in_r_bits_last(in_r_bits_last),
    .in_b_valid(in_b_valid), .in_b_ready(in_b_ready), .in_b_bits_id(in_b_bits_id),
    .in_b_bits_resp(in_b_bits_resp),
    .out_ar_valid(out_ar_valid), .out_ar_ready(out_ar_ready), .out_ar_bits_addr(out_ar_bits_addr),
    .out_ar_bits_len(out_ar_bits_len), .out_ar_bits_size(out_ar_bits_size),
    .out_ar_bits_burst(out_ar_bits_burst), .out_ar_bits_id(out_ar_bits_id),
    .out_aw_valid(out_aw_valid), .out_aw_ready(out_aw_ready), .out_aw_bits_addr(out_aw_bits_addr),
    .out_aw_bits_len(out_aw_bits_len), .out_aw_bits_size(out_aw_bits_size),
    .out_aw_bits_burst(out_aw_bits_burst), .out_aw_bits_id(out_aw_bits_id),
    .out_w_valid(out_w_valid), .out_w_ready(out_w_ready), .out_w_bits_data(out_w_bits_data),
    .out_w_bits_strb(out_w_bits_strb), .out_w_bits_last(out_w_bits_last),
    .out_r_valid(out_r_valid), .out_r_ready(out_r_ready), .out_r_bits_id(out_r_bits_id),
    .out_r_bits_data(out_r_bits_data), .out_r_bits_resp(out_r_bits_resp),
    .out_r_bits_last(out_r_bits_last),
    .out_b_valid(out_b_valid), .out_b_ready(out_b_ready), .out_b_bits_id(out_b_bits_id),
    .out_b_bits_resp(out_b_bits_resp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    in_ar_bits_addr = {32'h0000_2000, 32'h0000_1000};
    in_ar_bits_len = '0; in_ar_bits_size = {3'd3, 3'd3}; in_ar_bits_burst = {2'd1, 2'd1};
    in_ar_bits_id = {5'd9, 5'd4};
    in_aw_bits_addr = {32'h0000_3000, 32'h0000_4000};
    in_aw_bits_len = {8'd3, 8'd0}; in_aw_bits_size = {3'd3, 3'd3}; in_aw_bits_burst = {2'd1, 2'd1};
    in_aw_bits_id = {5'd6, 5'd2};
    in_w_bits_data = '0; in_w_bits_strb = '1; in_w_bits_last = '0;
    out_r_bits_id = '0; out_r_bits_data = '0; out_r_bits_resp = '0; out_r_bits_last = 1'b0;
    out_b_bits_id = '0; out_b_bits_resp = '0;
    // Everything requesting while reset is held
    in_ar_valid = 2'b11; in_aw_valid = 2'b11; in_w_valid = 2'b11;
    out_ar_ready = 1'b1; out_aw_ready = 1'b1; out_w_ready = 1'b1;
    out_r_valid = 1'b1; out_b_valid = 1'b1; in_r_ready = 2'b11; in_b_ready = 2'b11;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_ar_valid", out_ar_valid, 0);
    chk("rst_out_aw_valid", out_aw_valid, 0);
    chk("rst_out_w_valid", out_w_valid, 0);
    chk("rst_in_ar_ready", in_ar_ready, 0);
    chk("rst_in_aw_ready", in_aw_ready, 0);
    chk("rst_in_w_ready", in_w_ready, 0);
    chk("rst_in_r_valid", in_r_valid, 0);
    chk("rst_out_r_ready", out_r_ready, 0);

    // Round-robin AR: both ports request, grants alternate starting at port 0
    @(posedge clock); #1;
    reset = 1'b0; in_aw_valid = '0; in_w_valid = '0; out_r_valid = 1'b0; out_b_valid = 1'b0;
    in_r_ready = '0; in_b_ready = '0;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clock); #2; end
      chk("rr_ar_id", out_ar_bits_id, (k % 2 == 1) ? 64'h29 : 64'h04);
      chk("rr_ar_ready", in_ar_ready, (k % 2 == 1) ? 64'h2 : 64'h1);
      chk("rr_ar_addr", out_ar_bits_addr, (k % 2 == 1) ? 64'h2000 : 64'h1000);
    end

    // Grant lock: port 1 offered but stalled; port 0 arriving later must not steal it
    @(posedge clock); #1;
    in_ar_valid = 2'b10; out_ar_ready = 1'b0;
    #1 chk("lock_first_id", out_ar_bits_id, 64'h29);
    @(posedge clock); #1;
    in_ar_valid = 2'b11;
    #1 chk("lock_hold_id", out_ar_bits_id, 64'h29);
    chk("lock_hold_ready", in_ar_ready, 0);
    @(posedge clock); #1;
    out_ar_ready = 1'b1;
    #1 chk("lock_release_ready", in_ar_ready, 2'b10);
    @(posedge clock); #2;
    chk("after_lock_id", out_ar_bits_id, 64'h04);
    in_ar_valid = '0; out_ar_ready = 1'b0;

    // Write ordering: AW port 1 (len 3) then port 0 (len 0); both W streams valid early
    @(posedge clock); #1;
    in_aw_valid = 2'b10; out_aw_ready = 1'b1; out_w_ready = 1'b1;
    in_w_valid = 2'b11; in_w_bits_data = {64'h100, 64'h200}; in_w_bits_last = 2'b01;
    #1 chk("aw1_id", out_aw_bits_id, 64'h26);
    chk("aw1_len", out_aw_bits_len, 3);
    chk("aw1_ready", in_aw_ready, 2'b10);
    chk("w_before_aw_valid", out_w_valid, 0);
    chk("w_before_aw_ready", in_w_ready, 0);
    @(posedge clock); #1;
    in_aw_valid = 2'b01;
    #1 chk("aw0_id", out_aw_bits_id, 64'h02);
    chk("aw0_ready", in_aw_ready, 2'b01);
    chk("w_p1_beat0", out_w_bits_data, 64'h100);
    chk("w_p1_beat0_rdy", in_w_ready, 2'b10);
    for (int k = 1; k < 4; k++) begin
      @(posedge clock); #1;
      in_aw_valid = '0;
      in_w_bits_data[127:64] = 64'h100 + 64'(k);
      in_w_bits_last[1] = (k == 3);
      #1 chk("w_p1_beat", out_w_bits_data, 64'h100 + 64'(k));
      chk("w_p1_last", out_w_bits_last, (k == 3) ? 64'h1 : 64'h0);
      chk("w_p0_stalled", in_w_ready, 2'b10);
    end
    @(posedge clock); #1;
    in_w_valid = 2'b01;
    #1 chk("w_p0_data", out_w_bits_data, 64'h200);
    chk("w_p0_ready", in_w_ready, 2'b01);
    chk("w_p0_last", out_w_bits_last, 1);
    @(posedge clock); #1;
    in_w_valid = '0; in_w_bits_last = '0;
    #1 chk("wq_empty_valid", out_w_valid, 0);

    // Queue full: four AWs with no W fill the queue, fifth waits for a pop
    @(posedge clock); #1;
    in_aw_valid = 2'b01;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clock); #2; end
      chk("wq_fill_ready", in_aw_ready, 2'b01);
    end
    @(posedge clock); #2;
    chk("wq_full_ready", in_aw_ready, 0);
    chk("wq_full_valid", out_aw_valid, 0);
    @(posedge clock); #1;
    in_w_valid = 2'b01; in_w_bits_last = 2'b01;
    #1 chk("wq_pop_wready", in_w_ready, 2'b01);
    chk("wq_full_during_pop", in_aw_ready, 0);
    @(posedge clock); #1;
    in_w_valid = '0;
    #1 chk("wq_after_pop", in_aw_ready, 2'b01);

    // Reset mid-burst; first move rd_ptr to 1 so the post-reset winner is meaningful
    @(posedge clock); #1;
    in_aw_valid = '0; in_w_valid = 2'b01; in_w_bits_last = '0;
    in_ar_valid = 2'b01; out_ar_ready = 1'b1;
    #1 chk("burst_active", out_w_valid, 1);
    @(posedge clock); #1;
    reset = 1'b1; in_ar_valid = 2'b11; in_aw_valid = 2'b11;
    out_r_valid = 1'b1; in_r_ready = 2'b11;
    @(posedge clock); #2;
    chk("midrst_out_w_valid", out_w_valid, 0);
    chk("midrst_in_w_ready", in_w_ready, 0);
    chk("midrst_out_ar_valid", out_ar_valid, 0);
    chk("midrst_in_ar_ready", in_ar_ready, 0);
    chk("midrst_out_aw_valid", out_aw_valid, 0);
    chk("midrst_in_aw_ready", in_aw_ready, 0);
    chk("midrst_in_r_valid", in_r_valid, 0);
    chk("midrst_out_r_ready", out_r_ready, 0);
    @(posedge clock); #1;
    reset = 1'b0; in_aw_valid = '0; out_r_valid = 1'b0; in_r_ready = '0;
    #1 chk("post_rst_ar_id", out_ar_bits_id, 64'h04);
    chk("post_rst_ar_ready", in_ar_ready, 2'b01);
    chk("post_rst_wq_empty", out_w_valid, 0);
    in_ar_valid = '0; in_w_valid = '0; out_ar_ready = 1'b0;

    // Response routing by ID prefix
    @(posedge clock); #1;
    out_r_valid = 1'b1; out_r_bits_id = 6'h23; out_r_bits_data = 64'hDEAD; in_r_ready = 2'b10;
    #1 chk("r_valid_p1", in_r_valid, 2'b10);
    chk("r_id_p1", in_r_bits_id[9:5], 3);
    chk("r_data_p1", in_r_bits_data[127:64], 64'hDEAD);
    chk("r_ready_p1", out_r_ready, 1);
    @(posedge clock); #1;
    in_r_ready = 2'b01;
    #1 chk("r_backpressure", out_r_ready, 0);
    chk("r_valid_hold", in_r_valid, 2'b10);
    @(posedge clock); #1;
    out_r_bits_id = 6'h07;
    #1 chk("r_valid_p0", in_r_valid, 2'b01);
    chk("r_id_p0", in_r_bits_id[4:0], 7);
    chk("r_ready_p0", out_r_ready, 1);
    @(posedge clock); #1;
    out_r_valid = 1'b0; out_b_valid = 1'b1; out_b_bits_id = 6'h22; in_b_ready = 2'b01;
    #1 chk("b_valid_p1", in_b_valid, 2'b10);
    chk("b_id_p1", in_b_bits_id[9:5], 2);
    chk("b_backpressure", out_b_ready, 0);
    @(posedge clock); #1;
    in_b_ready = 2'b10;
    #1 chk("b_ready_p1", out_b_ready, 1);
    @(posedge clock); #1;
    out_b_valid = 1'b0; in_b_ready = '0;

`ifdef AXI_MEM_ARB_LIMIT_EN
    // Per-port limit of 2 outstanding reads
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; in_ar_valid = 2'b01; out_ar_ready = 1'b1;
    #1 chk("lim_ar_first", in_ar_ready, 2'b01);
    @(posedge clock); #2;
    chk("lim_ar_second", in_ar_ready, 2'b01);
    @(posedge clock); #1;
    in_ar_valid = 2'b11;
    #1 chk("lim_p0_blocked", in_ar_ready, 2'b10);
    chk("lim_p1_id", out_ar_bits_id, 64'h29);
    @(posedge clock); #1;
    in_ar_valid = 2'b01;
    out_r_valid = 1'b1; out_r_bits_id = 6'h00; out_r_bits_last = 1'b1; in_r_ready = 2'b01;
    #1 chk("lim_at_max", out_ar_valid, 0);
    @(posedge clock); #1;
    out_r_valid = 1'b0;
    #1 chk("lim_eligible", in_ar_ready, 2'b01);
    in_ar_valid = '0; out_ar_ready = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_mem_arbiter.md
# axi_mem_arbiter

Round-robin AXI4 arbiter sharing one simulated DRAM port (the SimDRAM DPI model) between `N_PORTS` masters. AR and AW are arbitrated independently. Port index is prepended to the transaction ID so R and B responses route back without lookup state. W beats are steered by an in-order queue of granted AW ports. The block sits between the memory-side crossbar outputs and the single SimDRAM instance in the simulation harness.

## Interface
- `N_PORTS`, 2: number of upstream masters; must be at least 2.
- `ADDR_BITS`, 32: address width.
- `DATA_BITS`, 64: data width. `STRB_BITS` = `DATA_BITS/8`.
- `ID_BITS`, 5: upstream ID width. `PORT_BITS` = `$clog2(N_PORTS)`.
- `WQ_DEPTH`, 4: W-routing queue depth; power of two.
- `MAX_OUTSTANDING`, 8: per-port limit, used only under `AXI_MEM_ARB_LIMIT_EN`.
- `clock`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high.
- `in_ar_*`  in/out  per port, packed `[N_PORTS*W-1:0]`: `valid`, `ready`, `bits_addr`, `bits_len[7:0]`, `bits_size[2:0]`, `bits_burst[1:0]`, `bits_id[ID_BITS-1:0]`.
- `in_aw_*`  in/out  per port: same fields as `in_ar_*`.
- `in_w_*`  in/out  per port: `valid`, `ready`, `bits_data`, `bits_strb`, `bits_last`.
- `in_r_*`  out/in  per port: `valid`, `ready`, `bits_id`, `bits_data`, `bits_resp[1:0]`, `bits_last`.
- `in_b_*`  out/in  per port: `valid`, `ready`, `bits_id`, `bits_resp[1:0]`.
- `out_ar_*`, `out_aw_*`, `out_w_*`, `out_r_*`, `out_b_*`: single downstream port with the same fields. ID width is `ID_BITS+PORT_BITS`.

## Operation
- **Read arbitration**
  - Candidates are the ports with `in_ar_valid`.
  - The winner is the first valid port at or after `rd_ptr`, searching in round-robin order.
  - `out_ar` carries the winner's fields, with `out_ar_bits_id = {port, in_id}`.
  - Only the winner's `in_ar_ready` follows `out_ar_ready`; all other ports see 0.
- **Grant lock**: when `out_ar_valid && !out_ar_ready`, the grant is registered and held until the handshake. This keeps `out_ar` stable, as AXI requires. Same rule for AW.
- **Pointer update**: on an AR handshake from port p, `rd_ptr <= (p+1) mod N_PORTS`. Same rule for `wr_ptr` on AW.
- **Write arbitration**
  - Same round-robin scheme using `wr_ptr`.
  - An AW handshake is permitted only when the W queue is not full.
  - On the handshake, the granted port index is pushed into the W queue.
- **W routing**
  - When the queue is non-empty, its head port h drives `out_w`.
  - `in_w_ready[h] = out_w_ready`; all other ports see 0.
  - A W handshake with `last` pops the queue.
  - When the queue is empty, `out_w_valid = 0`.
- **W before AW**: W may arrive at the arbiter before its AW. It is stalled (ready = 0) until its port reaches the queue head.
- **R routing**
  - Target port p = `out_r_bits_id[ID_BITS+PORT_BITS-1:ID_BITS]`.
  - `in_r_valid[p] = out_r_valid`; `in_r_bits_id` carries the low `ID_BITS`.
  - `out_r_ready = in_r_ready[p]`.
  - A target index ≥ `N_PORTS` is dropped: `out_r_ready = 1`, and no upstream valid is asserted.
- **B routing**: same as R.
- **Simultaneous push and pop** on the W queue: both take effect. A full queue with a pop in the same cycle still refuses the new AW. The full flag is registered with no bypass.

## Timing
- AR, AW, W, R and B are combinational pass-through: 0 cycles latency, no bubbles inserted.
- Back-to-back AR grants to alternating ports are sustained at 1 per cycle.
- During `reset`, all `out_*_valid` and `in_*_ready` are forced to 0.
- Reset state: `rd_ptr = wr_ptr = 0`, locks clear, W queue empty.
- Reset mid-burst abandons in-flight state with no recovery. SimDRAM is reset in the same cycle.
- Port 0 wins all ties in the first cycle after reset.

## Configuration
- **With `AXI_MEM_ARB_LIMIT_EN` defined**
  - Each port has read and write outstanding counters, each `$clog2(MAX_OUTSTANDING+1)` bits.
  - The read counter increments on AR handshake and decrements on R handshake with `last`. The write counter increments on AW handshake and decrements on B handshake.
  - A simultaneous increment and decrement leaves the counter unchanged.
  - A port at `MAX_OUTSTANDING` is excluded from arbitration candidates.
- **Without it**: no counters, and ports are never excluded.

## Structure
- Package `axi_mem_arb_pkg`:
  - `PORT_BITS` function.
  - Typedefs `axi_resp_t` (2 bits) and `axi_burst_t`.
  - Constants `AXI_RESP_OKAY` and `AXI_RESP_DECERR`.
- Sub-module `axi_mem_arb_fifo`: synchronous FIFO holding port indices (width `PORT_BITS`, depth `WQ_DEPTH`) with `full`/`empty`. Used for the W queue.
- Round-robin pick is a function in the package, shared by the AR and AW paths.

## Test plan
- **Round-robin AR**: ports 0 and 1 hold AR valid with `out_ar_ready=1` → grants 0,1,0,1. `out_ar_bits_id` = `{0,id}` / `{1,id}`.
- **Write ordering**:
  - Sequence: AW from port 1 (len 3), then port 0 (len 0); both W streams valid from cycle 0.
  - Required: `out_w` shows 4 beats from port 1, then 1 from port 0.
  - Port 0 W stays stalled throughout port 1's burst.
- **Queue full** (`WQ_DEPTH=4`): 4 AW accepted with no W → 5th `in_aw_ready=0` until one W `last` pops.
- **Response routing**:
  - `out_r_bits_id = {1,5'd3}` → only `in_r_valid[1]`, with id 3.
  - Backpressure `in_r_ready[1]=0` → `out_r_ready=0`.
- **Reset mid-burst**: assert reset during a W burst → next cycle all valids/readys are 0. After release, port 0 wins the first AR.
- **With `AXI_MEM_ARB_LIMIT_EN`, `MAX_OUTSTANDING=2`**: port 0 issues 2 ARs and no R returns → 3rd AR blocked while port 1 is granted. One R `last` → port 0 eligible next cycle.
